main_memory_responder: RTL

- Responder end of the cache-to-memory refill interface: the backing-store side that the L1 cache controller initiates requests against.
- Serves line-refill reads and write-through word writes with a configurable access latency.
- Every request returns a full 512-bit line; for a write, the returned line already contains the new word.
- Word array is internal; responses are assembled by a sequential 16-beat burst.

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_word_array.sv | 22 ++
 rtl/main_memory_responder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants and state encoding for the cache-refill memory responder.
package mem_pkg;
    localparam int unsigned LINE_WORDS  = 16;
    localparam int unsigned LINE_BITS   = 512;
    localparam int unsigned OFFSET_BITS = 4;
    localparam int unsigned WORD_BITS   = 32;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        WRITE,
        BURST,
        RESP
    } state_t;
endpackage

// File: rtl/mem_word_array.sv
// Single-port backing store: synchronous write, combinational read, no reset.
module mem_word_array
    import mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_WORDS)-1:0] addr,
    input  logic [WORD_BITS-1:0]         wdata,
    output logic [WORD_BITS-1:0]         rdata
);
    logic [WORD_BITS-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/main_memory_responder.sv
// Memory side of the L1 refill interface: optional word write, then a 16-beat line read-back.
module main_memory_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 4096,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WORD_BITS-1:0]  req_wdata,
    output logic                  resp_valid,
    output logic                  resp_write,
    output logic [LINE_BITS-1:0]  resp_line,
    output logic                  busy
);
    localparam int unsigned AW    = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [OFFSET_BITS-1:0] beat_q, beat_d;
    logic [AW-1:0]          addr_q;
    logic                   write_q;
    logic [WORD_BITS-1:0]   wdata_q;
    logic [LINE_BITS-1:0]   line_q;
    logic                   resp_valid_q, resp_write_q;

    logic                   mem_we;
    logic [AW-1:0]          mem_addr;
    logic [WORD_BITS-1:0]   mem_rdata;

    // Byte-lane and aliased upper address bits carry no information here.
    logic unused_addr;
    assign unused_addr = ^{req_addr[ADDR_WIDTH-1:AW+2], req_addr[1:0]};

    mem_word_array #(
        .MEM_WORDS(MEM_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(wdata_q),
        .rdata(mem_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        mem_we   = 1'b0;
        mem_addr = {addr_q[AW-1:OFFSET_BITS], beat_q};
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cnt_d  = '0;
                    beat_d = '0;
                    if (LATENCY > 0) state_d = WAIT;
                    else if (req_write) state_d = WRITE;
                    else state_d = BURST;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    cnt_d   = '0;
                    state_d = write_q ? WRITE : BURST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE: begin
                mem_we   = 1'b1;
                mem_addr = addr_q;
                state_d  = BURST;
            end
            BURST: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == OFFSET_BITS'(LINE_WORDS - 1)) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            beat_q       <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            line_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            if (state_q == IDLE && req_valid) begin
                addr_q  <= req_addr[AW+1:2];
                write_q <= req_write;
                wdata_q <= req_wdata;
            end
            if (state_q == BURST) begin
                line_q[{beat_q, 5'd0} +: WORD_BITS] <= mem_rdata;
            end
            // Response is registered out of RESP, giving the LATENCY+W+17 edge count.
            resp_valid_q <= (state_q == RESP);
            if (state_q == RESP) resp_write_q <= write_q;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_write = resp_write_q;
    assign resp_line  = line_q;
endmodule
